// File: rtl/uart_cmd_tx_if.sv
// Command-side handshake for uart_cmd_tx.
//   send     : request strobe, taken only while ready
//   cmd_type : type character sent as byte 1 ('M' / 'G' / anything)
//   cmd_data : 16-bit command word, high byte first on the line
//   ready    : block can take a send this cycle
//   busy     : packet on the line
//   done     : one-cycle pulse after the last stop bit
//   oData    : UART serial line, idles high
interface uart_cmd_tx_if;
  logic        send;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_data;
  logic        ready;
  logic        busy;
  logic        done;
  logic        oData;

  modport slave  (input  send, cmd_type, cmd_data,
                  output ready, busy, done, oData);
  modport master (output send, cmd_type, cmd_data,
                  input  ready, busy, done, oData);
endinterface

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: frames one 16-bit command as a 4-byte 8N1 UART packet
// {START_CHAR, cmd_type, cmd_data[15:8], cmd_data[7:0]} and shifts it out.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_cmd_tx_if.slave (send/cmd_type/cmd_data in,
//           ready/busy/done/oData out)
module uart_cmd_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] START_CHAR   = 8'h21
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_cmd_tx_if.slave bus
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud,  w_baud_nxt;
  logic [2:0]    r_bit,   w_bit_nxt;
  logic [1:0]    r_byte,  w_byte_nxt;
  logic [31:0]   r_pkt,   w_pkt_nxt;
  logic          r_odata, w_odata_nxt;
  logic          w_accept;
  logic          w_bit_end;
  logic [7:0]    w_cur_byte;

  // DONE also accepts, giving back-to-back packets with a one-cycle idle gap.
  assign w_accept  = bus.send && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_pkt_nxt   = r_pkt;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_byte_nxt  = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_pkt_nxt   = {START_CHAR, bus.cmd_type, bus.cmd_data};
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte != 2'd3) begin
            w_byte_nxt  = r_byte + 2'd1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is computed from the next state so oData comes straight
  // off a flop with no decode glitches.
  always_comb begin
    w_cur_byte = 8'hFF;
    case (w_byte_nxt)
      2'd0: w_cur_byte = w_pkt_nxt[31:24];
      2'd1: w_cur_byte = w_pkt_nxt[23:16];
      2'd2: w_cur_byte = w_pkt_nxt[15:8];
      2'd3: w_cur_byte = w_pkt_nxt[7:0];
      default: w_cur_byte = 8'hFF;
    endcase
    w_odata_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_odata_nxt = 1'b0;
      S_DATA:  w_odata_nxt = w_cur_byte[w_bit_nxt];
      default: w_odata_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_pkt   <= '0;
      r_odata <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_pkt   <= w_pkt_nxt;
      r_odata <= w_odata_nxt;
    end
  end

  assign bus.ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign bus.busy  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign bus.done  = (r_state == S_DONE);
  assign bus.oData = r_odata;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: two instances (4 and 434 clks/bit), each checked
// every cycle against a cycle-count model of the packet waveform.
module tb_uart_cmd_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fin   = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input int tag, input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL cpb%0d %s: got %0h expected %0h", tag, nm, act, exp);
  endtask

  // Expected line bits of one packet, index 0 = first start bit.
  function automatic logic [39:0] build_frame(input logic [7:0] t, input logic [15:0] d);
    logic [7:0]  b [4];
    logic [39:0] f;
    b = '{8'h21, t, d[15:8], d[7:0]};
    f = '1;
    for (int i = 0; i < 4; i++) begin
      f[i*10] = 1'b0;
      for (int j = 0; j < 8; j++) f[i*10+1+j] = b[i][j];
      f[i*10+9] = 1'b1;
    end
    return f;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int CPB  = (g == 0) ? 4 : 434;
    localparam int LAST = 40*CPB + 1;

    logic rst_n;
    uart_cmd_tx_if u_if ();
    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .START_CHAR(8'h21)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );

    // Model: m_k = 0 idle, 1..40*CPB cycles into the packet, LAST = done cycle.
    int          m_k = 0;
    logic [39:0] m_frame = '1;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_k <= 0;
      else if ((m_k == 0 || m_k == LAST) && u_if.send === 1'b1) begin
        m_k     <= 1;
        m_frame <= build_frame(u_if.cmd_type, u_if.cmd_data);
      end else if (m_k != 0) m_k <= (m_k == LAST) ? 0 : m_k + 1;
    end

    always @(negedge clk) begin
      int e_o, e_r, e_b, e_d;
      if (chk_en) begin
        if (m_k == 0)         begin e_o = 1; e_r = 1; e_b = 0; e_d = 0; end
        else if (m_k == LAST) begin e_o = 1; e_r = 1; e_b = 0; e_d = 1; end
        else begin e_o = int'(m_frame[(m_k-1)/CPB]); e_r = 0; e_b = 1; e_d = 0; end
        chk(CPB, "oData", int'(u_if.oData), e_o);
        chk(CPB, "ready", int'(u_if.ready), e_r);
        chk(CPB, "busy",  int'(u_if.busy),  e_b);
        chk(CPB, "done",  int'(u_if.done),  e_d);
      end
    end

    if (g == 0) begin : st4
      initial begin
        int n, gap, sel;
        u_if.send = 1'b0; u_if.cmd_type = '0; u_if.cmd_data = '0;
        rst_n = 1'b1; #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // random traffic, including sends while busy and in DONE
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          u_if.send     = ($urandom_range(0, 5) == 0);
          sel           = int'($urandom_range(0, 2));
          u_if.cmd_type = (sel == 0) ? 8'h4D : (sel == 1) ? 8'h47 : 8'($urandom);
          u_if.cmd_data = 16'($urandom);
        end
        @(negedge clk); u_if.send = 1'b0;
        n = 0; while (m_k != 0 && n < 1000) begin @(negedge clk); n++; end
        chk(CPB, "drain to idle", m_k, 0);
        // accept-to-done latency
        u_if.send = 1'b1; u_if.cmd_type = 8'h47; u_if.cmd_data = 16'h1234;
        @(negedge clk); u_if.send = 1'b0;
        n = 1; while (!u_if.done && n < 1000) begin @(negedge clk); n++; end
        chk(CPB, "accept->done cycles", n, 161);
        // back-to-back with send held high
        @(negedge clk);
        u_if.send = 1'b1; u_if.cmd_type = 8'h4D; u_if.cmd_data = 16'hF128;
        @(negedge clk);
        n = 0; while (!u_if.done && n < 1000) begin @(negedge clk); n++; end
        gap = 0; while (u_if.oData && gap < 10) begin gap++; @(negedge clk); end
        chk(CPB, "b2b idle gap", gap, 1);
        chk(CPB, "b2b second busy", int'(u_if.busy), 1);
        u_if.send = 1'b0;
        n = 0; while (m_k != 0 && n < 1000) begin @(negedge clk); n++; end
        // reset during byte 2, bit 4
        u_if.send = 1'b1; u_if.cmd_type = 8'h4D; u_if.cmd_data = 16'hC3A5;
        @(negedge clk); u_if.send = 1'b0;
        repeat (101) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk(CPB, "reset oData", int'(u_if.oData), 1);
        chk(CPB, "reset busy",  int'(u_if.busy),  0);
        chk(CPB, "reset ready", int'(u_if.ready), 1);
        chk(CPB, "reset done",  int'(u_if.done),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        u_if.send = 1'b1; u_if.cmd_type = 8'h47; u_if.cmd_data = 16'h5A5A;
        @(negedge clk); u_if.send = 1'b0;
        n = 1; while (!u_if.done && n < 1000) begin @(negedge clk); n++; end
        chk(CPB, "post-reset accept->done", n, 161);
        repeat (3) @(negedge clk);
        n_fin++;
      end
    end else begin : st434
      bit          go = 1'b0;
      int          done_cnt = 0;
      logic [7:0]  rxq [$];

      always @(negedge clk) if (chk_en && rst_n && u_if.done) done_cnt++;

      // independent line decoder, samples mid-bit
      initial begin
        logic [7:0] b;
        wait (go);
        forever begin
          @(negedge clk);
          if (u_if.oData == 1'b0) begin
            repeat (CPB/2) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
              repeat (CPB) @(negedge clk);
              b[j] = u_if.oData;
            end
            repeat (CPB) @(negedge clk);
            rxq.push_back(b);
          end
        end
      end

      initial begin
        int n;
        u_if.send = 1'b0; u_if.cmd_type = '0; u_if.cmd_data = '0;
        rst_n = 1'b1; #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; go = 1'b1;
        repeat (5) @(negedge clk);
        u_if.send = 1'b1; u_if.cmd_type = 8'h4D; u_if.cmd_data = 16'hF128;
        @(negedge clk);
        u_if.send = 1'b0; u_if.cmd_type = 8'h47; u_if.cmd_data = 16'h0000;
        n = 1;
        while (!u_if.done && n < 20000) begin
          @(negedge clk); n++;
          if (n == 5000) begin u_if.send = 1'b1; u_if.cmd_data = 16'hAAAA; end
          else u_if.send = 1'b0;
        end
        chk(CPB, "accept->done cycles", n, 17361);
        repeat (3*CPB) @(negedge clk);
        chk(CPB, "done pulse count", done_cnt, 1);
        chk(CPB, "decoded byte count", rxq.size(), 4);
        if (rxq.size() == 4) begin
          chk(CPB, "byte0", int'(rxq[0]), 'h21);
          chk(CPB, "byte1", int'(rxq[1]), 'h4D);
          chk(CPB, "byte2", int'(rxq[2]), 'hF1);
          chk(CPB, "byte3", int'(rxq[3]), 'h28);
        end
        n_fin++;
      end
    end
  end

  initial begin
    #5 chk_en = 1'b1;
    for (int c = 0; c < 60000 && n_fin < 2; c++) @(negedge clk);
    if (n_fin < 2) chk(0, "finish timeout", n_fin, 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
